// File: rtl/relu_maxpool.sv
// ReLU followed by 2x2 stride-2 max pooling over a raster-order pixel stream.
// One half-width row buffer holds horizontal pair maxima from even rows until the odd row combines them.
module relu_maxpool #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] pixel_i,
  input  logic       pix_data_valid,
  output logic [7:0] pool_o,
  output logic       pool_valid_o,
  output logic       frame_done_o
);

  localparam int DATA_W = 8;
  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = $clog2(IMG_W);
  localparam int RW     = $clog2(IMG_H);
  localparam int IW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam bit H_ODD  = (IMG_H % 2) == 1;

  localparam logic [CW-1:0] COL_LAST     = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_DONE     = CW'(2 * HALF_W - 1);
  localparam logic [RW-1:0] ROW_LAST     = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_DONE     = RW'(2 * (IMG_H / 2) - 1);
  localparam logic [RW-1:0] ROW_PRE_SKIP = RW'(IMG_H - 2);

  typedef enum logic [1:0] {ROW_EVEN, ROW_ODD, SKIP} state_t;

  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] xs;
    xs = x;
    relu = (SIGNED_IN && (xs < 0)) ? '0 : x;
  endfunction

  function automatic logic [DATA_W-1:0] max8(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    max8 = (a > b) ? a : b;
  endfunction

  state_t            state;
  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] hold_p0;
  logic [DATA_W-1:0] row_buf [HALF_W];
  logic [DATA_W-1:0] relu_p0;
  logic [DATA_W-1:0] pair_p0;
  logic [IW-1:0]     buf_idx;

  // Stage p0: ReLU and horizontal pair maximum on the accepted pixel
  always_comb begin
    relu_p0 = relu(pixel_i);
    pair_p0 = max8(hold_p0, relu_p0);
    buf_idx = IW'(col >> 1);
  end

  // An odd trailing column of an odd-width image lands on an even col and only ever reaches hold_p0.
  always_ff @(posedge clk_i) begin
    if (pix_data_valid) begin
      if (!col[0])
        hold_p0 <= relu_p0;
      else if (state == ROW_EVEN)
        row_buf[buf_idx] <= pair_p0;
    end
  end

  // Stage p1: registered pooled output, counters and row FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pool_o       <= '0;
      pool_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
      col          <= '0;
      row          <= '0;
      state        <= ROW_EVEN;
    end else begin
      pool_valid_o <= 1'b0;
      frame_done_o <= 1'b0;
      if (pix_data_valid) begin
        if (col[0] && (state == ROW_ODD)) begin
          pool_o       <= max8(row_buf[buf_idx], pair_p0);
          pool_valid_o <= 1'b1;
          frame_done_o <= (row == ROW_DONE) && (col == COL_DONE);
        end
        if (col == COL_LAST) begin
          col <= '0;
          if (row == ROW_LAST) begin
            row   <= '0;
            state <= ROW_EVEN;
          end else begin
            row <= row + 1'b1;
            case (state)
              ROW_EVEN: state <= ROW_ODD;
              ROW_ODD:  state <= (H_ODD && (row == ROW_PRE_SKIP)) ? SKIP : ROW_EVEN;
              default:  state <= ROW_EVEN;
            endcase
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule
